main_mem_responder: RTL

//  Main-memory end of the cache's line-refill/write-back interface: cache (initiator) raises
//  mem_rd_req or mem_wr_req with a line address; this block answers after a fixed latency with
//  a one-cycle mem_gnt, returning or storing a whole line. Used as the backing store under cache
//  in cache-level benches and CPU integration.

---
 rtl/cache_mem_pkg.sv | 16 +
 rtl/mem_line_ram.sv | 31 +++
 rtl/main_mem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types for the cache/main-memory refill interface.
// Line type is rebuilt per instance from LINE_SIZE.
package cache_mem_pkg;

  localparam int WORD_W = 32;
  localparam int DEF_LINE_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef logic [DEF_LINE_SIZE-1:0][WORD_W-1:0] def_line_t;

endpackage

// File: rtl/mem_line_ram.sv
// Line-wide storage: one synchronous read port, one synchronous write port.
// Contents are zero at time 0 and are never touched by reset.
module mem_line_ram
  import cache_mem_pkg::*;
#(
  parameter int ADDR_LEN  = 6,
  parameter int LINE_SIZE = 8
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [ADDR_LEN-1:0]              wr_addr,
  input  logic [LINE_SIZE-1:0][WORD_W-1:0] wr_line,
  input  logic [ADDR_LEN-1:0]              rd_addr,
  output logic [LINE_SIZE-1:0][WORD_W-1:0] rd_line
);

  typedef logic [LINE_SIZE-1:0][WORD_W-1:0] line_t;

  line_t mem [2**ADDR_LEN] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_line;
    end
  end

  always_ff @(posedge clk) begin
    rd_line <= mem[rd_addr];
  end

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder for cache line refills and write-backs.
// Answers each request with a one-cycle mem_gnt LATENCY cycles after sampling.
module main_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 6,
  parameter int LATENCY       = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    mem_rd_req,
  input  logic                                    mem_wr_req,
  input  logic [ADDR_LEN-1:0]                     mem_addr,
  input  logic [2**LINE_ADDR_LEN-1:0][WORD_W-1:0] mem_wr_line,
  output logic [2**LINE_ADDR_LEN-1:0][WORD_W-1:0] mem_rd_line,
  output logic                                    mem_gnt,
  output logic [31:0]                             rd_cnt,
  output logic [31:0]                             wr_cnt
);

  localparam int LINE_SIZE = 2**LINE_ADDR_LEN;

  typedef logic [LINE_SIZE-1:0][WORD_W-1:0] line_t;

  mem_state_t          state;
  logic [7:0]          cnt;
  logic                op_wr;
  logic [ADDR_LEN-1:0] addr_q;
  line_t               line_q;
  line_t               ram_q;
  logic [ADDR_LEN-1:0] ram_rd_addr;
  logic                done;
  logic                ram_we;

  assign done = (state == WAIT) && (cnt == 8'd0);
  assign ram_we = done && op_wr && !rst;

  // In IDLE the read port tracks the live address so ram_q is
  // already valid one cycle after sampling, even for LATENCY=1.
  assign ram_rd_addr = (state == IDLE) ? mem_addr : addr_q;

  mem_line_ram #(
    .ADDR_LEN (ADDR_LEN),
    .LINE_SIZE(LINE_SIZE)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .wr_addr(addr_q),
    .wr_line(line_q),
    .rd_addr(ram_rd_addr),
    .rd_line(ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      op_wr       <= 1'b0;
      addr_q      <= '0;
      line_q      <= '0;
      mem_gnt     <= 1'b0;
      mem_rd_line <= '0;
      rd_cnt      <= 32'd0;
      wr_cnt      <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          mem_gnt <= 1'b0;
          if (mem_wr_req || mem_rd_req) begin
            op_wr  <= mem_wr_req;
            addr_q <= mem_addr;
            line_q <= mem_wr_line;
            cnt    <= 8'(LATENCY - 1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            if (op_wr) begin
              wr_cnt <= wr_cnt + 32'd1;
            end else begin
              mem_rd_line <= ram_q;
              rd_cnt      <= rd_cnt + 32'd1;
            end
            mem_gnt <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          mem_gnt <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          mem_gnt <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
